// File: rtl/i2s_frame_sched_if.sv
// Frame handshake bundle between two audio sources, the scheduler and the i2s transmitter.
// master: sources plus transmitter side; slave: the scheduler.
interface i2s_frame_sched_if #(
   parameter int WIDTH = 16
);
   logic               s0_valid;
   logic [2*WIDTH-1:0] s0_data;
   logic               s0_ready;
   logic               s1_valid;
   logic [2*WIDTH-1:0] s1_data;
   logic               s1_ready;
   logic               tx_ready;
   logic [2*WIDTH-1:0] Tx;
   logic               src_sel;

   modport master (
      output s0_valid, s0_data, s1_valid, s1_data, tx_ready,
      input  s0_ready, s1_ready, Tx, src_sel
   );

   modport slave (
      input  s0_valid, s0_data, s1_valid, s1_data, tx_ready,
      output s0_ready, s1_ready, Tx, src_sel
   );
endinterface

// File: rtl/i2s_frame_sched.sv
// Two-source round-robin frame scheduler feeding an i2s transmitter through a frame FIFO,
// with a prime phase before playback and saturating underrun accounting.
module i2s_frame_sched #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 4,
   parameter int PRIME_LVL = DEPTH / 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   i2s_frame_sched_if.slave           bus,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic                       underrun,
   output logic [7:0]                 underrun_cnt
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = 2 * WIDTH;
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_PRIME = LW'(PRIME_LVL);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t         state;
   logic [FW:0]    mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           last_grant;

   logic           accept_open;
   logic           gnt0;
   logic           gnt1;
   logic           push;
   logic           pop;
   logic           push_tag;
   logic [FW-1:0]  push_data;

   // Full test uses the start-of-cycle level, so a same-cycle pop never frees a slot.
   always_comb begin
      accept_open  = enable && (state != IDLE) && (fifo_level != LVL_FULL);
      gnt0         = bus.s0_valid && (!bus.s1_valid || last_grant);
      gnt1         = bus.s1_valid && (!bus.s0_valid || !last_grant);
      bus.s0_ready = accept_open && gnt0;
      bus.s1_ready = accept_open && gnt1;
      push         = bus.s0_ready || bus.s1_ready;
      push_tag     = bus.s1_ready;
      push_data    = bus.s1_ready ? bus.s1_data : bus.s0_data;
      pop          = (state == RUN) && bus.tx_ready && (fifo_level != '0);
   end

   // NOTE: the frame storage has no reset; flushing the pointers and level is enough
   // to discard its contents, and leaving it unreset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {push_tag, push_data};
   end

   // NOTE: every register here uses <= so all updates see start-of-cycle values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         fifo_level   <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         bus.Tx       <= '0;
         bus.src_sel  <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= 8'd0;
         last_grant   <= 1'b1;
      end else begin
         underrun <= 1'b0;
         if (!enable) begin
            state       <= IDLE;
            fifo_level  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            bus.Tx      <= '0;
            bus.src_sel <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr     <= wr_ptr + 1'b1;
               last_grant <= push_tag;
            end

            case (state)
               IDLE:  state <= PRIME;
               PRIME: if (fifo_level >= LVL_PRIME) state <= RUN;
               RUN: begin
                  if (bus.tx_ready) begin
                     if (pop) begin
                        bus.Tx      <= mem[rd_ptr][FW-1:0];
                        bus.src_sel <= mem[rd_ptr][FW];
                        rd_ptr      <= rd_ptr + 1'b1;
                     end else begin
                        // Empty: send silence, keep the previous tag, no bypass of a same-cycle push.
                        bus.Tx   <= '0;
                        underrun <= 1'b1;
                        if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase

            case ({push, pop})
               2'b10:   fifo_level <= fifo_level + 1'b1;
               2'b01:   fifo_level <= fifo_level - 1'b1;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2s_frame_sched.sv
// Directed bench for i2s_frame_sched: a reference model tracks state and arbitration,
// and a frame queue holds expected FIFO contents until the transmitter pulls them.
module tb_i2s_frame_sched;
   localparam int WIDTH     = 16;
   localparam int DEPTH     = 4;
   localparam int PRIME_LVL = 2;
   localparam int FW        = 2 * WIDTH;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable;
   logic [2:0] fifo_level;
   logic       underrun;
   logic [7:0] underrun_cnt;

   always #5 clk = ~clk;

   i2s_frame_sched_if #(.WIDTH(WIDTH)) bus ();

   i2s_frame_sched #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .bus(bus),
      .fifo_level(fifo_level),
      .underrun(underrun),
      .underrun_cnt(underrun_cnt)
   );

   typedef enum {M_IDLE, M_PRIME, M_RUN} mstate_t;

   mstate_t       m_state;
   bit            m_lg;
   int            m_cnt;
   logic [FW-1:0] m_tx;
   bit            m_sel;
   bit            m_und;
   logic [FW:0]   sb [$];
   logic [FW-1:0] d0;
   logic [FW-1:0] d1;
   int            vectors;
   int            miscompares;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE;
      m_lg    = 1'b1;
      m_cnt   = 0;
      m_tx    = '0;
      m_sel   = 1'b0;
      m_und   = 1'b0;
      sb.delete();
   endtask

   // One clock: drive at posedge+1, check ready at negedge, check registered outputs at posedge+1.
   task automatic step(input bit en, input bit v0, input bit v1, input bit txr);
      bit          r0, r1, open;
      int          lvl;
      logic [FW:0] head;
      enable       = en;
      bus.s0_valid = v0;
      bus.s0_data  = d0;
      bus.s1_valid = v1;
      bus.s1_data  = d1;
      bus.tx_ready = txr;
      @(negedge clk);
      lvl  = sb.size();
      open = en && (m_state != M_IDLE) && (lvl != DEPTH);
      r0   = open && v0 && (!v1 || m_lg);
      r1   = open && v1 && (!v0 || !m_lg);
      check("s0_ready", bus.s0_ready, r0);
      check("s1_ready", bus.s1_ready, r1);
      m_und = 1'b0;
      if (!en) begin
         m_state = M_IDLE;
         sb.delete();
         m_tx  = '0;
         m_sel = 1'b0;
      end else begin
         if (m_state == M_RUN && txr) begin
            if (lvl > 0) begin
               head  = sb.pop_front();
               m_tx  = head[FW-1:0];
               m_sel = head[FW];
            end else begin
               m_tx  = '0;
               m_und = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
         end
         case (m_state)
            M_IDLE:  m_state = M_PRIME;
            M_PRIME: if (lvl >= PRIME_LVL) m_state = M_RUN;
            default: ;
         endcase
         if (r0) begin
            sb.push_back({1'b0, d0});
            m_lg = 1'b0;
         end else if (r1) begin
            sb.push_back({1'b1, d1});
            m_lg = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (r0) d0++;
      if (r1) d1++;
      check("Tx", bus.Tx, m_tx);
      check("src_sel", bus.src_sel, m_sel);
      check("fifo_level", fifo_level, sb.size());
      check("underrun", underrun, m_und);
      check("underrun_cnt", underrun_cnt, m_cnt);
   endtask

   // Asserts reset between edges and checks outputs before any clock edge arrives.
   task automatic async_reset();
      #2 rst = 1'b0;
      enable       = 1'b0;
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      bus.tx_ready = 1'b0;
      #1;
      check("rst_Tx", bus.Tx, 0);
      check("rst_src_sel", bus.src_sel, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_underrun", underrun, 0);
      check("rst_underrun_cnt", underrun_cnt, 0);
      check("rst_s0_ready", bus.s0_ready, 0);
      check("rst_s1_ready", bus.s1_ready, 0);
      model_reset();
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      enable       = 1'b0;
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      bus.s0_data  = '0;
      bus.s1_data  = '0;
      bus.tx_ready = 1'b0;
      d0           = 32'hAAAA0001;
      d1           = 32'hBBBB0001;
      model_reset();

      @(posedge clk);
      #1;
      async_reset();
      step(0, 0, 0, 0);

      // Prime with both sources contending; tx_ready in PRIME is ignored.
      step(1, 1, 1, 0);
      step(1, 1, 1, 1);
      check("prime_tx_hold", bus.Tx, 0);
      step(1, 1, 1, 0);
      check("prime_level", fifo_level, 2);
      step(1, 0, 0, 0);

      // Three pulses with two frames queued: two frames then one underrun.
      step(1, 0, 0, 1);
      check("first_tx", bus.Tx, 32'hAAAA0001);
      check("first_sel", bus.src_sel, 0);
      check("first_level", fifo_level, 1);
      step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      check("second_tx", bus.Tx, 32'hBBBB0001);
      check("second_sel", bus.src_sel, 1);
      step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      check("empty_tx", bus.Tx, 0);
      check("empty_underrun", underrun, 1);
      check("empty_cnt", underrun_cnt, 1);
      step(1, 0, 0, 0);
      check("underrun_one_cycle", underrun, 0);

      // Full FIFO: a same-cycle pop does not admit a push.
      repeat (4) step(1, 1, 1, 0);
      check("full_level", fifo_level, 4);
      step(1, 1, 0, 1);
      check("full_pop_level", fifo_level, 3);
      check("full_pop_tx", bus.Tx, 32'hAAAA0002);
      step(1, 1, 0, 0);
      check("refill_level", fifo_level, 4);
      repeat (4) begin
         step(1, 0, 0, 1);
         step(1, 0, 0, 0);
      end

      // Push and pull on an empty FIFO: underrun, frame retained.
      step(1, 1, 0, 1);
      check("nobypass_underrun", underrun, 1);
      check("nobypass_tx", bus.Tx, 0);
      check("nobypass_level", fifo_level, 1);
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      repeat (300) begin
         step(1, 0, 0, 1);
         step(1, 0, 0, 0);
      end
      check("cnt_saturated", underrun_cnt, 255);

      // Disable mid-stream flushes but keeps the underrun count.
      repeat (3) step(1, 1, 0, 0);
      check("pre_disable_level", fifo_level, 3);
      step(0, 1, 0, 0);
      check("disable_level", fifo_level, 0);
      check("disable_tx", bus.Tx, 0);
      check("disable_cnt", underrun_cnt, 255);

      // Reset mid-operation, then the first tie goes to s0 again.
      step(1, 0, 0, 0);
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      async_reset();
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      check("post_reset_sel", bus.src_sel, 0);
      step(1, 0, 0, 1);
      check("post_reset_sel2", bus.src_sel, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
